cim_bit_serializer: RTL and testbench



---
 rtl/cim_bit_serializer.sv | 160 ++++++++++++++++
 tb/tb_cim_bit_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_bit_serializer.sv
// -----------------------------------------------------------------------------
// cim_bit_serializer
//
// Front end of the bit-serial CIM datapath. A parallel vector of ROWS unsigned
// activation words is accepted on a valid/ready port and streamed to the CIM
// array as bit-planes, MSB first, one plane per clock. The block drives the
// clear/run control (st) of the external shift-accumulator, captures the final
// accumulator value one cycle after the last plane, and returns it on a
// valid/ready result port.
//
// Ports:
//   clk        clock, all logic on posedge
//   rstn       synchronous active-low reset
//   in_valid   activation vector valid
//   in_ready   block can accept a vector (IDLE only)
//   in_data    ROWS*DATA_W activation words, row r at [r*DATA_W +: DATA_W]
//   abort      synchronous cancel of the current operation
//   act_bits   current bit-plane, bit r = row r's bit (0 whenever st=1)
//   plane_idx  bit index of the current plane (DATA_W-1 down to 0)
//   st         accumulator control: 1 = clear/hold cleared, 0 = accumulate
//   acc_nout   accumulator registered output
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   captured accumulation result
//   busy       high in any state other than IDLE
// -----------------------------------------------------------------------------
module cim_bit_serializer #(
  parameter int ROWS   = 8,
  parameter int DATA_W = 24,
  parameter int ACC_W  = 51,
  localparam int CNT_W = $clog2(DATA_W)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   abort,
  output logic [ROWS-1:0]        act_bits,
  output logic [CNT_W-1:0]       plane_idx,
  output logic                   st,
  input  logic [ACC_W-1:0]       acc_nout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    load_s;
  logic [ROWS*DATA_W-1:0]  shreg_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [ACC_W-1:0]        out_data_r;
  logic [DATA_W-1:0]       rows_s [ROWS];
  logic [ROWS-1:0]         act_s;

  // State, vector store, plane counter and result capture registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= IDLE;
      shreg_r    <= {(ROWS*DATA_W){1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      out_data_r <= {ACC_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        shreg_r <= in_data;
        cnt_r   <= CNT_W'(DATA_W - 1);
      end else if (state_r == STREAM) begin
        // An aborted stream parks the counter at 0 so plane_idx reads 0 in IDLE.
        cnt_r <= abort ? {CNT_W{1'b0}} : (cnt_r - {{(CNT_W-1){1'b0}}, 1'b1});
      end
      // The accumulator registered the last plane on the previous edge, so
      // acc_nout holds the final sum during CAPTURE.
      if ((state_r == CAPTURE) && !abort) begin
        out_data_r <= acc_nout;
      end
    end
  end

  // Next-state and accept decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // abort wins over a coincident in_valid
        if (in_valid && !abort) begin
          state_s = STREAM;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = CAPTURE;
        end else begin
          state_s = STREAM;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      HOLD: begin
        if (abort || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Per-row view of the stored vector.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      rows_s[r] = shreg_r[r*DATA_W +: DATA_W];
    end
  end

  // Bit-plane select; zero outside STREAM so the array never sees stale planes.
  always_comb begin
    act_s = {ROWS{1'b0}};
    if (state_r == STREAM) begin
      for (int r = 0; r < ROWS; r++) begin
        act_s[r] = rows_s[r][cnt_r];
      end
    end else begin
      act_s = {ROWS{1'b0}};
    end
  end

  // All outputs decode directly from registered state.
  assign act_bits  = act_s;
  assign plane_idx = cnt_r;
  assign st        = (state_r != STREAM);
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == HOLD);
  assign busy      = (state_r != IDLE);
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_cim_bit_serializer.sv
module tb_cim_bit_serializer;

  localparam int ROWS = 2;
  localparam int DW   = 4;
  localparam int AW   = 51;
  localparam int BR   = 8;
  localparam int BDW  = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, in_valid, abort, out_ready;
  logic              in_ready, st, out_valid, busy;
  logic [ROWS*DW-1:0] in_data;
  logic [ROWS-1:0]   act_bits;
  logic [1:0]        plane_idx;
  logic [AW-1:0]     acc_nout = '0;
  logic [AW-1:0]     out_data;

  logic              d_in_valid, d_in_ready, d_st, d_out_valid, d_busy;
  logic [BR*BDW-1:0] d_in_data;
  logic [BR-1:0]     d_act_bits;
  logic [4:0]        d_plane_idx;
  logic [AW-1:0]     d_acc_nout = '0;
  logic [AW-1:0]     d_out_data;

  cim_bit_serializer #(.ROWS(ROWS), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .act_bits(act_bits), .plane_idx(plane_idx),
    .st(st), .acc_nout(acc_nout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  cim_bit_serializer #(.ROWS(BR), .DATA_W(BDW), .ACC_W(AW)) dut_d (
    .clk(clk), .rstn(rstn), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .abort(abort), .act_bits(d_act_bits), .plane_idx(d_plane_idx),
    .st(d_st), .acc_nout(d_acc_nout), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data), .busy(d_busy)
  );

  // Model of the external array + shift-accumulator: partial = popcount of plane.
  always @(posedge clk) begin
    if (st === 1'b0) acc_nout <= (acc_nout << 1) + AW'($countones(act_bits));
    else             acc_nout <= '0;
    if (d_st === 1'b0) d_acc_nout <= (d_acc_nout << 1) + AW'($countones(d_act_bits));
    else               d_acc_nout <= '0;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [AW-1:0] exp_sum;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Full-visibility run of one vector on the small instance, starting in IDLE.
  task automatic run_vec(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                         input logic [AW-1:0] exp_sum);
    logic [DW-1:0] t0, t1;
    chk("vec.in_ready", in_ready, 1);
    in_data  = {r1, r0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = DW - 1; k >= 0; k--) begin
      t0 = r0 >> k;
      t1 = r1 >> k;
      chk("vec.st_low", st, 0);
      chk("vec.plane_idx", plane_idx, k);
      chk("vec.act_bits", act_bits, {t1[0], t0[0]});
      tick();
    end
    chk("vec.capture_st", st, 1);
    chk("vec.capture_act", act_bits, 0);
    chk("vec.capture_nvalid", out_valid, 0);
    tick();
    chk("vec.out_valid", out_valid, 1);
    chk("vec.out_data", out_data, exp_sum);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("vec.idle_ready", in_ready, 1);
    chk("vec.idle_nvalid", out_valid, 0);
  endtask

  initial begin
    int falls[$];
    int nres, w, d;
    logic prev_st;
    logic [DW-1:0] r0, r1;
    logic [AW-1:0] held;

    tbl[0] = '{4'hB, 4'h6, 51'd17};
    tbl[1] = '{4'h0, 4'h0, 51'd0};
    tbl[2] = '{4'hF, 4'hF, 51'd30};
    tbl[3] = '{4'h1, 4'h0, 51'd1};
    tbl[4] = '{4'h8, 4'h8, 51'd16};
    tbl[5] = '{4'h5, 4'hA, 51'd15};

    rstn = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    in_data = '0; d_in_valid = 1'b0; d_in_data = '0;
    tick(); tick();
    chk("rst.in_ready", in_ready, 1);
    chk("rst.st", st, 1);
    chk("rst.act_bits", act_bits, 0);
    chk("rst.plane_idx", plane_idx, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.out_data", out_data, 0);
    rstn = 1'b1;
    tick();

    // Table-driven vectors with plane-by-plane checking.
    for (int i = 0; i < 6; i++) run_vec(tbl[i].r0, tbl[i].r1, tbl[i].exp_sum);

    // Reset held 2 cycles mid-stream.
    in_data = 8'hFF; in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    chk("mrst.streaming", st, 0);
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
    chk("mrst.st", st, 1);
    chk("mrst.act_bits", act_bits, 0);
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.in_ready", in_ready, 1);
    chk("mrst.busy", busy, 0);
    chk("mrst.out_data", out_data, 0);
    tick();
    chk("mrst.stay_idle", busy, 0);

    // Backpressure: hold the result for 10 cycles while in_valid pulses.
    in_data = {4'h6, 4'hB}; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (5) tick();
    chk("bp.out_valid_cycle6", out_valid, 1);
    for (int j = 0; j < 10; j++) begin
      in_valid = j[0];
      in_data  = 8'hFF;
      tick();
      chk("bp.valid_held", out_valid, 1);
      chk("bp.data_held", out_data, 17);
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp.idle_ready", in_ready, 1);
    chk("bp.idle_busy", busy, 0);
    chk("bp.data_after", out_data, 17);

    // Back-to-back all-ones vectors with out_ready high.
    in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    prev_st = st; nres = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (prev_st && !st) falls.push_back(cyc);
      if (out_valid) begin
        chk("b2b.result", out_data, 30);
        nres++;
      end
      prev_st = st;
    end
    in_valid = 1'b0;
    chk("b2b.nres_ge2", (nres >= 2), 1);
    chk("b2b.nfalls_ge2", (falls.size() >= 2), 1);
    if (falls.size() >= 2) chk("b2b.spacing", falls[1] - falls[0], DW + 3);
    abort = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0; tick();
    chk("b2b.flushed", in_ready, 1);

    // Abort mid-stream at plane_idx=1.
    held = out_data;
    in_data = 8'hFF; in_valid = 1'b1; tick(); in_valid = 1'b0;
    w = 0;
    while (plane_idx !== 2'd1 && w < 8) begin tick(); w++; end
    chk("abt.reach_plane1", plane_idx, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abt.st", st, 1);
    chk("abt.in_ready", in_ready, 1);
    chk("abt.busy", busy, 0);
    chk("abt.act_bits", act_bits, 0);
    chk("abt.out_valid", out_valid, 0);
    chk("abt.out_data", out_data, held);
    repeat (3) tick();
    chk("abt.no_result", out_valid, 0);
    run_vec(4'h0, 4'h0, 51'd0);

    // Abort coinciding with in_valid in IDLE: no accept.
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF; tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abt_idle.busy", busy, 0);

    // Abort in HOLD drops the result.
    in_data = {4'h3, 4'h4}; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (5) tick();
    chk("abt_hold.valid", out_valid, 1);
    chk("abt_hold.data", out_data, 7);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abt_hold.dropped", out_valid, 0);
    chk("abt_hold.idle", in_ready, 1);

    // Randomized vectors against arithmetic sum, with noise and backpressure.
    for (int n = 0; n < 25; n++) begin
      r0 = 4'($urandom_range(0, 15));
      r1 = 4'($urandom_range(0, 15));
      in_data = {r1, r0}; in_valid = 1'b1; tick();
      w = 0;
      while (out_valid !== 1'b1 && w < 20) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        tick();
        w++;
      end
      in_valid = 1'b0;
      chk("rnd.latency", w, DW + 1);
      chk("rnd.sum", out_data, r0 + r1);
      d = $urandom_range(0, 3);
      repeat (d) tick();
      chk("rnd.held", out_valid, 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("rnd.idle", in_ready, 1);
    end

    // Default-parameter instance: all rows 24'hFFFFFF.
    d_in_data = '1; d_in_valid = 1'b1; tick(); d_in_valid = 1'b0;
    w = 0;
    while (d_out_valid !== 1'b1 && w < 60) begin tick(); w++; end
    chk("big.latency", w, BDW + 1);
    chk("big.sum", d_out_data, 64'd134217720);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("big.idle", d_in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
